// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue
//   Sequential instruction prefetcher. It issues word-stepped fetches to an
//   in-order, handshaked memory port with up to MAX_OUTSTANDING requests in
//   flight. Returned instructions are buffered with their PCs in a DEPTH-entry
//   queue and handed to decode over a valid/ready handshake. A redirect flushes
//   the queue, marks every in-flight request as stale and restarts fetch at the
//   new PC.
//
// Ports
//   clk_i              clock
//   reset_i            synchronous, active-high reset
//   redirect_valid_i   flush and restart fetch at redirect_pc_i
//   redirect_pc_i      new fetch address
//   mem_req_valid_o    fetch request valid
//   mem_req_ready_i    memory accepts the request
//   mem_req_addr_o     request address (current fetch PC)
//   mem_resp_valid_i   response valid (in order, at most one per cycle)
//   mem_resp_data_i    fetched instruction
//   out_valid_o        instruction available to decode
//   out_ready_i        decode accepts
//   out_instruction_o  head instruction
//   out_pc_o           address of head instruction
//
// Optional build macro
//   FETCH_BYPASS_EN    a fresh response arriving while the queue is empty is
//                      presented to decode in the same cycle; it is only
//                      written into the queue if decode does not take it.

module fetch_prefetch_queue #(
    parameter int unsigned     XLEN            = 32,
    parameter int unsigned     DEPTH           = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2,
    parameter int unsigned     PC_STEP         = 1,
    parameter logic [XLEN-1:0] RESET_PC        = 'h3000
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            mem_req_valid_o,
    input  logic            mem_req_ready_i,
    output logic [XLEN-1:0] mem_req_addr_o,
    input  logic            mem_resp_valid_i,
    input  logic [XLEN-1:0] mem_resp_data_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_instruction_o,
    output logic [XLEN-1:0] out_pc_o
);

    localparam int unsigned QAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned QCW = $clog2(DEPTH + 1);
    localparam int unsigned OCW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned FAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    // Fetch pointer and request accounting
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [OCW-1:0]  outst_q, outst_d;
    logic [OCW-1:0]  drop_q, drop_d;

    // PCs of accepted requests, in request order
    logic [XLEN-1:0] if_pc_q [MAX_OUTSTANDING];
    logic [FAW-1:0]  if_rd_q, if_rd_d;
    logic [FAW-1:0]  if_wr_q, if_wr_d;

    // Instruction queue
    logic [XLEN-1:0] q_pc_q    [DEPTH];
    logic [XLEN-1:0] q_instr_q [DEPTH];
    logic [QAW-1:0]  q_head_q, q_head_d;
    logic [QAW-1:0]  q_tail_q, q_tail_d;
    logic [QCW-1:0]  q_cnt_q, q_cnt_d;

    logic req_fire;
    logic resp_stale;
    logic resp_fresh;
    logic q_empty;
    logic q_push;
    logic q_pop;
    logic bypass;

    function automatic logic [FAW-1:0] if_inc(input logic [FAW-1:0] ptr);
        return (32'(ptr) == MAX_OUTSTANDING - 1) ? '0 : ptr + FAW'(1);
    endfunction

    assign q_empty    = (q_cnt_q == '0);
    assign resp_stale = (drop_q != '0);
    // A response in the redirect cycle belongs to the old stream either way.
    assign resp_fresh = mem_resp_valid_i && !resp_stale && !redirect_valid_i;

`ifdef FETCH_BYPASS_EN
    assign bypass = !reset_i && q_empty && resp_fresh;
`else
    assign bypass = 1'b0;
`endif

    // Stale requests still occupy a slot until their response comes back, so
    // queued + outstanding never exceeds DEPTH and the queue cannot overflow.
    assign mem_req_valid_o = !reset_i && !redirect_valid_i
                             && (32'(outst_q) < MAX_OUTSTANDING)
                             && (32'(q_cnt_q) + 32'(outst_q) < DEPTH);
    assign mem_req_addr_o  = fetch_pc_q;
    assign req_fire        = mem_req_valid_o && mem_req_ready_i;

    assign q_pop  = !q_empty && out_ready_i;
    assign q_push = resp_fresh && !(bypass && out_ready_i);

    assign out_valid_o       = !q_empty || bypass;
    assign out_instruction_o = bypass ? mem_resp_data_i   : q_instr_q[q_head_q];
    assign out_pc_o          = bypass ? if_pc_q[if_rd_q]  : q_pc_q[q_head_q];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        if_rd_d    = if_rd_q;
        if_wr_d    = if_wr_q;
        q_head_d   = q_head_q;
        q_tail_d   = q_tail_q;
        q_cnt_d    = q_cnt_q;

        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
            outst_d    = outst_d + OCW'(1);
            if_wr_d    = if_inc(if_wr_q);
        end
        if (mem_resp_valid_i) begin
            outst_d = outst_d - OCW'(1);
            if_rd_d = if_inc(if_rd_q);
            if (resp_stale) begin
                drop_d = drop_q - OCW'(1);
            end
        end

        if (q_push) begin
            q_tail_d = q_tail_q + QAW'(1);
        end
        if (q_pop) begin
            q_head_d = q_head_q + QAW'(1);
        end
        case ({q_push, q_pop})
            2'b10:   q_cnt_d = q_cnt_q + QCW'(1);
            2'b01:   q_cnt_d = q_cnt_q - QCW'(1);
            default: q_cnt_d = q_cnt_q;
        endcase

        // Everything still in flight after this cycle is from the old stream.
        if (redirect_valid_i) begin
            fetch_pc_d = redirect_pc_i;
            drop_d     = outst_d;
            q_head_d   = '0;
            q_tail_d   = '0;
            q_cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fetch_pc_q <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            if_rd_q    <= '0;
            if_wr_q    <= '0;
            q_head_q   <= '0;
            q_tail_q   <= '0;
            q_cnt_q    <= '0;
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                if_pc_q[i] <= '0;
            end
            for (int i = 0; i < int'(DEPTH); i++) begin
                q_pc_q[i]    <= '0;
                q_instr_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            if_rd_q    <= if_rd_d;
            if_wr_q    <= if_wr_d;
            q_head_q   <= q_head_d;
            q_tail_q   <= q_tail_d;
            q_cnt_q    <= q_cnt_d;
            if (req_fire) begin
                if_pc_q[if_wr_q] <= fetch_pc_q;
            end
            if (q_push) begin
                q_pc_q[q_tail_q]    <= if_pc_q[if_rd_q];
                q_instr_q[q_tail_q] <= mem_resp_data_i;
            end
        end
    end

`ifndef SYNTHESIS
    a_no_overflow : assert property (@(posedge clk_i) disable iff (reset_i)
        !(q_push && !q_pop && (32'(q_cnt_q) == DEPTH)));
    a_no_spurious_resp : assert property (@(posedge clk_i) disable iff (reset_i)
        !(mem_resp_valid_i && (outst_q == '0)));
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench for fetch_prefetch_queue: a directed vector table for the
// start-up/stall sequence, hand-written redirect and reset sequences, then
// randomized traffic checked against a queue-based reference model and an
// in-order delivery scoreboard. A second instance checks PC wrap-around.

module tb_fetch_prefetch_queue;

    localparam int unsigned     XLEN  = 32;
    localparam int unsigned     DEPTH = 4;
    localparam int unsigned     MAXO  = 2;
    localparam logic [XLEN-1:0] RPC   = 32'h3000;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            redirect_valid = 1'b0;
    logic [XLEN-1:0] redirect_pc = '0;
    logic            mem_req_valid;
    logic            mem_req_ready = 1'b0;
    logic [XLEN-1:0] mem_req_addr;
    logic            mem_resp_valid = 1'b0;
    logic [XLEN-1:0] mem_resp_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] out_instruction;
    logic [XLEN-1:0] out_pc;

    // Wrap-around instance with its own 1-cycle, always-ready memory
    logic            w_req_valid;
    logic [XLEN-1:0] w_req_addr;
    logic            w_resp_valid;
    logic [XLEN-1:0] w_resp_data;
    logic            w_out_valid;
    logic [XLEN-1:0] w_out_instruction;
    logic [XLEN-1:0] w_out_pc;

    always #5 clk = ~clk;

    fetch_prefetch_queue #(
        .XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .PC_STEP(1), .RESET_PC(RPC)
    ) dut (
        .clk_i(clk), .reset_i(reset),
        .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
        .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
        .mem_req_addr_o(mem_req_addr),
        .mem_resp_valid_i(mem_resp_valid), .mem_resp_data_i(mem_resp_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_instruction_o(out_instruction), .out_pc_o(out_pc)
    );

    fetch_prefetch_queue #(
        .XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .PC_STEP(1),
        .RESET_PC(32'hFFFF_FFFE)
    ) dut_w (
        .clk_i(clk), .reset_i(reset),
        .redirect_valid_i(1'b0), .redirect_pc_i(32'h0),
        .mem_req_valid_o(w_req_valid), .mem_req_ready_i(1'b1),
        .mem_req_addr_o(w_req_addr),
        .mem_resp_valid_i(w_resp_valid), .mem_resp_data_i(w_resp_data),
        .out_valid_o(w_out_valid), .out_ready_i(1'b1),
        .out_instruction_o(w_out_instruction), .out_pc_o(w_out_pc)
    );

    function automatic logic [XLEN-1:0] fdat(input logic [XLEN-1:0] a);
        return {a[7:0], a[31:8]} ^ 32'h5A5A_1234;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            w_resp_valid <= 1'b0;
            w_resp_data  <= '0;
        end else begin
            w_resp_valid <= w_req_valid;
            w_resp_data  <= fdat(w_req_addr);
        end
    end

    typedef struct {
        logic [XLEN-1:0] addr;
        int              due;
    } mreq_t;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data;
    } entry_t;

    typedef struct {
        logic            ordy;
        logic            rv;
        logic [XLEN-1:0] addr;
        logic            ov;
        logic [XLEN-1:0] pc;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int mem_lat = 1;
    int mem_last_due = -1;
    mreq_t mem_q[$];

    // Reference model: fetch pointer, in-flight PCs, stale count and the queue
    logic [XLEN-1:0] m_fetch;
    int              m_outst;
    int              m_drop;
    logic [XLEN-1:0] m_infl[$];
    entry_t          m_q[$];
    logic [XLEN-1:0] m_next_pc;

    logic [XLEN-1:0] w_pcs[$];

    // Values sampled in the most recent step
    logic            s_req_valid, s_ov, s_hs, s_resp;
    logic [XLEN-1:0] s_addr, s_pc;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_fetch      = RPC;
        m_outst      = 0;
        m_drop       = 0;
        m_next_pc    = RPC;
        m_infl.delete();
        m_q.delete();
        mem_q.delete();
        mem_last_due = -1;
        w_pcs.delete();
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        mem_resp_valid = 1'b0;
        out_ready      = 1'b0;
        mem_req_ready  = 1'b1;
        @(negedge clk);
        chk("rst_req_valid_pre", 32'(mem_req_valid), 32'd0);
        @(posedge clk); #1; cyc++;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instruction", out_instruction, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_req_addr", mem_req_addr, RPC);
        chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
        @(posedge clk); #1; cyc++;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic step(input logic rv, input logic [XLEN-1:0] rpc, input logic ordy,
                        input logic qrdy);
        logic            exp_rv, byp, exp_ov, resp, fresh, accept;
        logic [XLEN-1:0] exp_pc, exp_ins, rpc_pc;
        int              due;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = ordy;
        mem_req_ready  = qrdy;
        resp           = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        mem_resp_valid = resp;
        mem_resp_data  = resp ? fdat(mem_q[0].addr) : $urandom();
        @(negedge clk);

        exp_rv = !rv && (m_outst < int'(MAXO)) && (m_q.size() + m_outst < int'(DEPTH));
        byp    = 1'b0;
`ifdef FETCH_BYPASS_EN
        byp = (m_q.size() == 0) && resp && (m_drop == 0) && !rv;
`endif
        exp_ov = (m_q.size() > 0) || byp;
        chk("mem_req_valid", 32'(mem_req_valid), 32'(exp_rv));
        chk("mem_req_addr", mem_req_addr, m_fetch);
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        if (exp_ov) begin
            if (m_q.size() > 0) begin
                exp_pc  = m_q[0].pc;
                exp_ins = m_q[0].data;
            end else begin
                exp_pc  = (m_infl.size() > 0) ? m_infl[0] : '0;
                exp_ins = mem_resp_data;
            end
            chk("out_pc", out_pc, exp_pc);
            chk("out_instruction", out_instruction, exp_ins);
        end

        s_req_valid = mem_req_valid;
        s_addr      = mem_req_addr;
        s_ov        = out_valid;
        s_pc        = out_pc;
        s_hs        = out_valid && ordy;
        s_resp      = resp;

        // In-order delivery scoreboard
        if (out_valid && ordy) begin
            chk("deliver_pc", out_pc, m_next_pc);
            chk("deliver_data", out_instruction, fdat(out_pc));
            m_next_pc = m_next_pc + 32'd1;
        end
        if (w_out_valid) begin
            w_pcs.push_back(w_out_pc);
        end

        // Memory environment follows the DUT's actual handshakes
        if (resp) begin
            void'(mem_q.pop_front());
        end
        if (mem_req_valid && qrdy) begin
            due = (cyc + mem_lat > mem_last_due + 1) ? cyc + mem_lat : mem_last_due + 1;
            mem_last_due = due;
            mem_q.push_back('{addr: mem_req_addr, due: due});
        end

        // Reference model update
        accept = exp_rv && qrdy;
        fresh  = 1'b0;
        rpc_pc = '0;
        if (resp) begin
            if (m_infl.size() > 0) rpc_pc = m_infl.pop_front();
            m_outst--;
            fresh = (m_drop == 0);
            if (!fresh) m_drop--;
        end
        if (rv) begin
            m_q.delete();
            m_drop    = m_outst;
            m_fetch   = rpc;
            m_next_pc = rpc;
        end else begin
            if (exp_ov && ordy && (m_q.size() > 0)) void'(m_q.pop_front());
            if (resp && fresh && !(byp && ordy)) m_q.push_back('{pc: rpc_pc, data: mem_resp_data});
        end
        if (accept) begin
            m_infl.push_back(m_fetch);
            m_fetch = m_fetch + 32'd1;
            m_outst++;
        end

        @(posedge clk); #1; cyc++;
    endtask

    task automatic wait_deliver(input string name, input logic [XLEN-1:0] exp);
        bit got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            step(1'b0, '0, 1'b1, 1'b1);
            if (s_hs) begin
                got = 1'b1;
                chk(name, s_pc, exp);
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s: no delivery within 30 cycles, expected pc %h", name, exp);
        end
    endtask

    initial begin
        int n_acc;
        int k;

        // Start-up with 1-cycle memory: stream at full rate, then stall decode.
`ifdef FETCH_BYPASS_EN
        tbl[0] = '{1'b1, 1'b1, 32'h3000, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 1'b1, 32'h3001, 1'b1, 32'h3000};
        tbl[2] = '{1'b1, 1'b1, 32'h3002, 1'b1, 32'h3001};
        tbl[3] = '{1'b1, 1'b1, 32'h3003, 1'b1, 32'h3002};
        tbl[4] = '{1'b1, 1'b1, 32'h3004, 1'b1, 32'h3003};
        tbl[5] = '{1'b0, 1'b1, 32'h3005, 1'b1, 32'h3004};
        tbl[6] = '{1'b0, 1'b1, 32'h3006, 1'b1, 32'h3004};
        tbl[7] = '{1'b0, 1'b1, 32'h3007, 1'b1, 32'h3004};
        tbl[8] = '{1'b0, 1'b0, 32'h3008, 1'b1, 32'h3004};
`else
        tbl[0] = '{1'b1, 1'b1, 32'h3000, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 1'b1, 32'h3001, 1'b0, 32'h0};
        tbl[2] = '{1'b1, 1'b1, 32'h3002, 1'b1, 32'h3000};
        tbl[3] = '{1'b1, 1'b1, 32'h3003, 1'b1, 32'h3001};
        tbl[4] = '{1'b1, 1'b1, 32'h3004, 1'b1, 32'h3002};
        tbl[5] = '{1'b0, 1'b1, 32'h3005, 1'b1, 32'h3003};
        tbl[6] = '{1'b0, 1'b1, 32'h3006, 1'b1, 32'h3003};
        tbl[7] = '{1'b0, 1'b0, 32'h3007, 1'b1, 32'h3003};
        tbl[8] = '{1'b0, 1'b0, 32'h3007, 1'b1, 32'h3003};
`endif

        model_clear();
        do_reset();
        mem_lat = 1;
        for (int i = 0; i < 9; i++) begin
            step(1'b0, '0, tbl[i].ordy, 1'b1);
            chk($sformatf("tbl%0d_req_valid", i), 32'(s_req_valid), 32'(tbl[i].rv));
            chk($sformatf("tbl%0d_req_addr", i), s_addr, tbl[i].addr);
            chk($sformatf("tbl%0d_out_valid", i), 32'(s_ov), 32'(tbl[i].ov));
            if (tbl[i].ov) chk($sformatf("tbl%0d_out_pc", i), s_pc, tbl[i].pc);
        end

        // PC wrap-around on the second instance
        if (w_pcs.size() < 3) begin
            checks++;
            errors++;
            $display("FAIL wrap_count: got %0d deliveries required at least 3", w_pcs.size());
        end else begin
            chk("wrap_pc0", w_pcs[0], 32'hFFFF_FFFE);
            chk("wrap_pc1", w_pcs[1], 32'hFFFF_FFFF);
            chk("wrap_pc2", w_pcs[2], 32'h0000_0000);
        end

        // Decode stalled for 10 cycles: exactly DEPTH requests, then drain in order
        do_reset();
        mem_lat = 1;
        n_acc = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, '0, 1'b0, 1'b1);
            if (s_req_valid) n_acc++;
        end
        chk("stall_accepts", 32'(n_acc), 32'd4);
        chk("stall_req_valid", 32'(s_req_valid), 32'd0);
        k = 0;
        for (int i = 0; i < 30 && k < 4; i++) begin
            step(1'b0, '0, 1'b1, 1'b1);
            if (s_hs) begin
                chk($sformatf("drain_pc%0d", k), s_pc, RPC + 32'(k));
                k++;
            end
        end
        chk("drain_count", 32'(k), 32'd4);

        // Redirect with two stale requests in flight on 3-cycle memory
        do_reset();
        mem_lat = 3;
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b1, 32'h4000, 1'b1, 1'b1);
        chk("redir3_req_valid", 32'(s_req_valid), 32'd0);
        step(1'b0, '0, 1'b1, 1'b1);
        chk("redir3_queue_empty", 32'(s_ov), 32'd0);
        wait_deliver("redir3_next_pc", 32'h4000);

        // Redirect coinciding with a response and a decode handshake
        do_reset();
        mem_lat = 1;
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 32'h5000, 1'b1, 1'b1);
        chk("redir_same_resp", 32'(s_resp), 32'd1);
        chk("redir_same_hs", 32'(s_ov), 32'd1);
        wait_deliver("redir_same_next_pc", 32'h5000);

        // Reset with requests outstanding and entries queued
        do_reset();
        mem_lat = 3;
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0, 1'b1);
        do_reset();
        mem_lat = 1;
        wait_deliver("post_reset_pc", RPC);

        // Randomized traffic against the reference model
        for (int i = 0; i < 4000; i++) begin
            if (i % 64 == 0) mem_lat = int'($urandom_range(1, 3));
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(0, 29) == 0), $urandom(),
                     ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
- Parametrised successor to the single-register PC fetch stage.
- Issues sequential instruction fetches to a handshaked, in-order memory port, supporting several outstanding requests.
- Buffers returned instructions with their PCs in a DEPTH-entry queue and presents them to decode over a valid/ready handshake.
- On a redirect (branch/JMP/TRAP), flushes the queue, discards stale in-flight responses and restarts fetch at the new PC.

Parameters:
- XLEN, 32: address and instruction width.
- DEPTH, 4: prefetch queue entries; power of two, ≥2.
- MAX_OUTSTANDING, 2: maximum accepted-but-unanswered memory requests; ≥1, ≤DEPTH.
- PC_STEP, 1: PC increment per fetch (word-addressed).
- RESET_PC, 32'h3000: fetch address after reset.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  XLEN  new fetch address.
- mem_req_valid  out  1  fetch request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  XLEN  request address (= fetch_pc).
- mem_resp_valid  in  1  response valid; in order, at most one per cycle, ≥1 cycle after acceptance.
- mem_resp_data  in  XLEN  fetched instruction.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode accepts.
- out_instruction  out  XLEN  head instruction.
- out_pc  out  XLEN  address of head instruction.

Behaviour:
- Reset, checked in the first clock after assertion:
  - fetch_pc=RESET_PC; queue empty.
  - Outstanding count, stale-drop count and in-flight PC FIFO all zero.
  - mem_req_valid=0, out_valid=0, out_instruction=0, out_pc=0.
  - mem_req_addr=RESET_PC.
  - Reset mid-operation abandons everything. Memory shares this reset, so no pre-reset responses arrive.
- Request issue:
  - mem_req_valid=1 iff not in reset, redirect_valid=0, outstanding<MAX_OUTSTANDING, and queue_count+outstanding<DEPTH (slot reservation).
  - Stale outstanding requests count toward both limits.
  - On accept (valid&&ready):
    - push fetch_pc into the in-flight PC FIFO;
    - fetch_pc += PC_STEP, modulo 2^XLEN (wraps silently);
    - outstanding++.
- Response:
  - Each mem_resp_valid decrements outstanding and pops the in-flight PC FIFO.
  - If drop_count>0 the response is stale: drop_count--, nothing queued.
  - Otherwise {pc, data} is pushed to the queue tail.
  - Reservation guarantees the queue never overflows. A push with the queue full is an assertion failure, not handled.
- Output:
  - out_valid = queue non-empty. out_instruction/out_pc = head entry, driven from registers.
  - Pop on out_valid&&out_ready.
  - Push and pop in the same cycle are both honoured; count is unchanged.
- Redirect, when redirect_valid=1 in cycle N:
  - Queue cleared at N+1.
  - Any response arriving in cycle N is discarded.
  - drop_count <= outstanding after cycle-N accounting.
  - fetch_pc <= redirect_pc; mem_req_valid=0 in cycle N.
  - A requests may issue from N+1 even while stale drops are pending.
  - An out handshake in cycle N still counts as transferred.
  - Back-to-back redirects: the last one wins; drop_count is recomputed each time.
- Latency, 1-cycle memory, out_ready=1, queue empty:
  - request accepted N, response N+1, out_valid N+2.
  - Sustained throughput is 1 instr/cycle when MAX_OUTSTANDING≥2.
- mem_req_addr is stable while mem_req_valid=1 and mem_req_ready=0.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined: when the queue is empty, the response is valid and not stale, and redirect_valid=0:
  - out_valid=1 combinationally in the response cycle, with out_instruction=mem_resp_data and out_pc = in-flight FIFO head.
  - If out_ready=1 the entry is not written to the queue; otherwise it is queued normally.
  - Latency drops to N+1.
- Undefined: every response passes through the queue; out_valid depends only on registers.

Test Plan:
- Reset, 1-cycle memory, out_ready=1 → out_pc sequence 0x3000, 0x3001, 0x3002… with out_instruction matching memory; first out_valid at the 3rd cycle after the first accept (2nd with FETCH_BYPASS_EN).
- out_ready=0 for 10 cycles, DEPTH=4 → exactly 4 accepted requests, mem_req_valid=0 thereafter; on out_ready=1 all 4 drain in order with no loss or duplication.
- 3-cycle memory latency, 2 requests outstanding, redirect_pc=0x4000 → both stale responses dropped; next delivered out_pc=0x4000; queue empty at the cycle after the redirect.
- Redirect in the same cycle as a response and an out handshake → response discarded, handshake counted, next out_pc=redirect_pc.
- RESET_PC=32'hFFFFFFFE, PC_STEP=1 → out_pc 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- Reset asserted with 2 outstanding and 3 queued → out_valid=0 and mem_req_addr=RESET_PC next cycle; fetch restarts cleanly.
